// File: rtl/laser_pkg.sv
// laser_pkg: shared constants, types and helpers for the laser cover scorer.
package laser_pkg;
  localparam int CW = 4;
  localparam int NPTS = 40;
  localparam int R2 = 16;
  typedef logic [CW-1:0] coord_t;
  typedef enum logic [1:0] {LOAD, WAIT, EVAL, REPORT} state_t;
  function automatic coord_t abs_diff(input coord_t a, input coord_t b);
    return (a > b) ? a - b : b - a;
  endfunction
endpackage

// File: rtl/laser_in_circle.sv
// laser_in_circle: combinational test of whether a point lies within R2 of a centre.
module laser_in_circle
  import laser_pkg::*;
(
  input  logic [CW-1:0] i_px,
  input  logic [CW-1:0] i_py,
  input  logic [CW-1:0] i_cx,
  input  logic [CW-1:0] i_cy,
  output logic          o_inside
);
  localparam int SW = 2*CW+1;
  coord_t w_dx, w_dy;
  logic [SW-1:0] w_d2;
  assign w_dx = abs_diff(i_px, i_cx);
  assign w_dy = abs_diff(i_py, i_cy);
  assign w_d2 = SW'(w_dx) * SW'(w_dx) + SW'(w_dy) * SW'(w_dy);
  assign o_inside = w_d2 <= SW'(R2);
endmodule

// File: rtl/laser_cover_scorer.sv
// laser_cover_scorer: stores a point stream, then scores the two reported circles against it.
// Optional SCORER_CHECK_EN adds EXP_SCORE input and a registered PASS verdict.
module laser_cover_scorer
  import laser_pkg::*;
(
  input  logic          CLK,
  input  logic          RST,
  input  logic          PT_VALID,
  input  logic [CW-1:0] X,
  input  logic [CW-1:0] Y,
  input  logic          DONE,
  input  logic [CW-1:0] C1X,
  input  logic [CW-1:0] C1Y,
  input  logic [CW-1:0] C2X,
  input  logic [CW-1:0] C2Y,
`ifdef SCORER_CHECK_EN
  input  logic [5:0]    EXP_SCORE,
  output logic          PASS,
`endif
  output logic [5:0]    SCORE,
  output logic [5:0]    OVERLAP,
  output logic          SCORE_VALID,
  output logic          ERR,
  output logic          BUSY
);
  localparam logic [5:0] LAST = 6'(NPTS-1);
  state_t r_state, w_next;
  logic [5:0] r_idx, r_score, r_overlap;
  logic [2*CW-1:0] r_mem [NPTS];
  logic [2*CW-1:0] w_pt;
  coord_t r_c1x, r_c1y, r_c2x, r_c2y;
  logic r_err, r_valid, w_in1, w_in2, w_last_load, w_early;
  assign w_pt = r_mem[r_idx];
  assign w_last_load = (r_state == LOAD) && PT_VALID && (r_idx == LAST);
  // DONE on the very cycle the last point lands is a legal handoff, not an early finish
  assign w_early = (r_state == LOAD) && DONE && !w_last_load;
  laser_in_circle u_c1 (.i_px(w_pt[2*CW-1:CW]), .i_py(w_pt[CW-1:0]), .i_cx(r_c1x), .i_cy(r_c1y), .o_inside(w_in1));
  laser_in_circle u_c2 (.i_px(w_pt[2*CW-1:CW]), .i_py(w_pt[CW-1:0]), .i_cx(r_c2x), .i_cy(r_c2y), .o_inside(w_in2));
  always_comb begin
    w_next = r_state;
    case (r_state)
      LOAD: w_next = w_early ? REPORT : w_last_load ? WAIT : LOAD;
      WAIT: w_next = DONE ? EVAL : WAIT;
      EVAL: w_next = (r_idx == LAST) ? REPORT : EVAL;
      default: w_next = REPORT;
    endcase
  end
  always_ff @(posedge CLK)
    if (r_state == LOAD && PT_VALID) r_mem[r_idx] <= {X, Y};
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= LOAD;
      r_idx <= '0;
      r_score <= '0;
      r_overlap <= '0;
      r_c1x <= '0;
      r_c1y <= '0;
      r_c2x <= '0;
      r_c2y <= '0;
      r_err <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      r_valid <= r_state == REPORT;
      if (w_early) r_err <= 1'b1;
      case (r_state)
        LOAD: if (PT_VALID) r_idx <= w_last_load ? '0 : r_idx + 6'd1;
        WAIT: if (DONE) begin
          r_c1x <= C1X;
          r_c1y <= C1Y;
          r_c2x <= C2X;
          r_c2y <= C2Y;
          r_idx <= '0;
        end
        EVAL: begin
          r_idx <= r_idx + 6'd1;
          r_score <= r_score + 6'(w_in1 | w_in2);
          r_overlap <= r_overlap + 6'(w_in1 & w_in2);
        end
        default: ;
      endcase
    end
  end
`ifdef SCORER_CHECK_EN
  logic r_pass;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_pass <= 1'b0;
    else if (r_state == REPORT && !r_valid) r_pass <= (r_score >= EXP_SCORE) && !r_err;
  end
  assign PASS = r_pass;
`endif
  assign SCORE = r_score;
  assign OVERLAP = r_overlap;
  assign SCORE_VALID = r_valid;
  assign ERR = r_err;
  assign BUSY = r_state != REPORT;
endmodule

// File: tb/tb_laser_cover_scorer.sv
// tb_laser_cover_scorer: directed self-checking bench for laser_cover_scorer.
module tb_laser_cover_scorer;
  logic       CLK = 0, RST = 0, PT_VALID = 0, DONE = 0;
  logic [3:0] X = 0, Y = 0, C1X = 0, C1Y = 0, C2X = 0, C2Y = 0;
  logic [5:0] SCORE, OVERLAP, EXP_SCORE = 0;
  logic       SCORE_VALID, ERR, BUSY, PASS;
  int n_pass = 0, n_total = 0;

  laser_cover_scorer dut (
    .CLK(CLK), .RST(RST), .PT_VALID(PT_VALID), .X(X), .Y(Y), .DONE(DONE),
    .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y),
`ifdef SCORER_CHECK_EN
    .EXP_SCORE(EXP_SCORE), .PASS(PASS),
`endif
    .SCORE(SCORE), .OVERLAP(OVERLAP), .SCORE_VALID(SCORE_VALID), .ERR(ERR), .BUSY(BUSY)
  );
`ifndef SCORER_CHECK_EN
  assign PASS = 1'b0;
`endif

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic chk_pass(input string tag, input logic exp);
`ifdef SCORER_CHECK_EN
    chk(tag, int'(PASS), int'(exp));
`endif
  endtask

  task automatic do_reset(input string tag);
    RST = 1; DONE = 0; PT_VALID = 0;
    #2;
    chk({tag, "_score"}, SCORE, 0);
    chk({tag, "_overlap"}, OVERLAP, 0);
    chk({tag, "_valid"}, SCORE_VALID, 0);
    chk({tag, "_err"}, ERR, 0);
    chk({tag, "_busy"}, BUSY, 1);
    chk_pass({tag, "_pass"}, 1'b0);
    @(negedge CLK); RST = 0;
    @(posedge CLK); #1;
  endtask

  task automatic load(input int n, input logic [3:0] ax, ay, bx, by, input bit gaps, input bit done_last);
    for (int i = 0; i < n; i++) begin
      PT_VALID = 1;
      X = (i % 2) ? bx : ax;
      Y = (i % 2) ? by : ay;
      DONE = done_last && (i == n - 1);
      @(posedge CLK); #1;
      if (gaps) begin
        PT_VALID = 0; X = 0; Y = 0;
        @(posedge CLK); #1;
      end
    end
    PT_VALID = 0;
  endtask

  task automatic centres(input logic [3:0] a, b, c, d, input logic [5:0] e);
    C1X = a; C1Y = b; C2X = c; C2Y = d; EXP_SCORE = e;
  endtask

  // raise DONE, scramble centres after the latch, and count edges until SCORE_VALID
  task automatic run(input string tag, input int lat, input int es, input int eo, input logic ep);
    int n;
    n = 0;
    DONE = 1;
    while (!SCORE_VALID && n < 200) begin
      @(posedge CLK); #1;
      n++;
      if (n == 2) centres(15, 15, 15, 15, EXP_SCORE);
      if (n == 3) chk({tag, "_busy_eval"}, BUSY, 1);
    end
    chk({tag, "_latency"}, n, lat);
    chk({tag, "_score"}, SCORE, es);
    chk({tag, "_overlap"}, OVERLAP, eo);
    chk({tag, "_err"}, ERR, 0);
    chk({tag, "_busy"}, BUSY, 0);
    chk_pass({tag, "_pass"}, ep);
    repeat (3) @(posedge CLK);
    #1;
    chk({tag, "_frozen"}, SCORE, es);
  endtask

  initial begin
    do_reset("rst0");
    // all points at centre 1, centre 2 far away
    centres(8, 8, 0, 0, 40);
    load(40, 8, 8, 8, 8, 0, 0);
    run("c1", 42, 40, 0, 1'b1);
    // alternating points each covered by exactly one circle
    do_reset("rst1");
    centres(2, 2, 13, 13, 41);
    load(40, 2, 2, 13, 13, 0, 0);
    run("alt", 42, 40, 0, 1'b0);
    // radius boundary: 16 inside, 17 outside
    do_reset("rst2");
    centres(0, 0, 8, 1, 40);
    load(40, 4, 0, 4, 0, 0, 0);
    run("bnd_out", 42, 40, 0, 1'b1);
    do_reset("rst3");
    centres(0, 0, 4, 4, 40);
    load(40, 4, 0, 4, 0, 0, 0);
    run("bnd_in", 42, 40, 40, 1'b1);
    // half the points in both circles, half in neither
    do_reset("rst4");
    centres(2, 2, 2, 6, 21);
    load(40, 2, 2, 13, 13, 0, 0);
    run("mix", 42, 20, 20, 1'b0);
    // early DONE after 25 points
    do_reset("rst5");
    centres(8, 8, 0, 0, 0);
    load(25, 8, 8, 8, 8, 0, 0);
    DONE = 1;
    @(posedge CLK); #1;
    chk("early_err", ERR, 1);
    chk("early_busy", BUSY, 0);
    chk("early_valid0", SCORE_VALID, 0);
    @(posedge CLK); #1;
    chk("early_valid1", SCORE_VALID, 1);
    chk("early_score", SCORE, 0);
    chk("early_overlap", OVERLAP, 0);
    chk_pass("early_pass", 1'b0);
    // gapped load; idle cycles carry (0,0) which neither circle covers
    do_reset("rst6");
    centres(8, 8, 15, 15, 40);
    load(40, 8, 8, 8, 8, 1, 0);
    chk("gap_busy_wait", BUSY, 1);
    DONE = 1;
    repeat (11) @(posedge CLK);
    #1;
    chk("gap_partial", SCORE, 10);
    RST = 1;
    #2;
    chk("midrst_score", SCORE, 0);
    chk("midrst_overlap", OVERLAP, 0);
    chk("midrst_valid", SCORE_VALID, 0);
    chk("midrst_busy", BUSY, 1);
    @(negedge CLK); RST = 0; DONE = 0;
    @(posedge CLK); #1;
    // rerun with DONE raised together with the last point
    centres(2, 2, 2, 6, 20);
    load(40, 2, 2, 13, 13, 0, 1);
    chk("last_done_err", ERR, 0);
    run("rerun", 42, 20, 20, 1'b1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/laser_cover_scorer.md
Name: laser_cover_scorer

Overview:
- Downstream checker for the two-circle laser placement stage.
- Snoops the same 40-point (X,Y) stream that feeds the placement stage and stores it locally.
- When the placement stage asserts DONE, latches the two reported centres and counts, over 40 evaluation cycles, the points covered by either circle and by both circles.
- Drives a stable score plus a valid flag for the testbench or system host.

Parameters:
- CW, 4, coordinate width in bits (grid 0..2^CW-1).
- NPTS, 40, points per run.
- R2, 16, squared radius; a point is inside when dx*dx+dy*dy <= R2.

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- RST  in  1  asynchronous active-high reset.
- PT_VALID  in  1  X/Y hold a valid point this cycle.
- X  in  CW  point x.
- Y  in  CW  point y.
- DONE  in  1  placement result valid; level, held high until reset.
- C1X, C1Y, C2X, C2Y  in  CW each  circle centres from placement stage.
- SCORE  out  6  points inside circle1 OR circle2.
- OVERLAP  out  6  points inside circle1 AND circle2.
- SCORE_VALID  out  1  SCORE/OVERLAP final.
- ERR  out  1  sticky: DONE seen before NPTS points loaded.
- BUSY  out  1  high in LOAD, WAIT, EVAL.

Behaviour:
- Reset: async active-high, takes effect immediately and may occur mid-run. All outputs and counters go to 0; state goes to LOAD; point memory contents are don't-care.
- States:
  - LOAD: each cycle with PT_VALID=1 writes mem[idx] and increments idx. After the write at idx=NPTS-1, go to WAIT. PT_VALID=0 holds idx.
  - WAIT: ignore PT_VALID. The first cycle DONE=1 latches C1X..C2Y into internal registers, clears idx, and goes to EVAL.
  - EVAL: each cycle evaluates mem[idx] against both latched centres.
    - dx = |px-cx| and dy = |py-cy| in CW bits; sum of squares in 2*CW+1 bits.
    - Increment SCORE if in1|in2; increment OVERLAP if in1&in2. No saturation is needed, since max 40 < 64.
    - After idx=NPTS-1, go to REPORT.
  - REPORT: SCORE_VALID=1. Outputs stay frozen until RST. DONE and PT_VALID are ignored.
- Latency: if DONE is first sampled high at edge N, SCORE_VALID rises after edge N+NPTS+1 (41 edges).
- DONE=1 during LOAD (early):
  - ERR=1 (sticky until RST).
  - Go directly to REPORT with SCORE=0 and OVERLAP=0.
  - SCORE_VALID=1 the following cycle.
- PT_VALID and DONE both high on the cycle the last point loads: the point is stored, ERR stays 0, and the next state is WAIT. DONE is still high, so WAIT exits on the next cycle.
- Centre input changes after the latch have no effect.
- BUSY=0 in REPORT.

Optional Feature:
- Macro: SCORER_CHECK_EN.
- Defined:
  - Adds input EXP_SCORE[5:0] and output PASS (reset 0).
  - PASS is registered and set in the same cycle SCORE_VALID rises, to (SCORE >= EXP_SCORE) && !ERR.
  - PASS is held while in REPORT.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Decomposition:
- Shared package laser_pkg:
  - CW, NPTS, R2 constants.
  - State enum (LOAD, WAIT, EVAL, REPORT).
  - Coordinate typedef.
  - An abs-difference function.
- Sub-module laser_in_circle: purely combinational (px, py, cx, cy -> inside). Instantiated twice, once per centre.

Test Plan:
- Load 40 points all at (8,8); DONE with C1=(8,8), C2=(0,0) -> SCORE=40, OVERLAP=0, SCORE_VALID 41 edges after DONE sampled.
- Points alternating (2,2)/(13,13), C1=(2,2), C2=(13,13) -> SCORE=40, OVERLAP=0.
- Boundary: 40 points at (4,0); C1=(0,0) (dist²=16, inside), C2=(8,1) (dist²=17, outside) -> SCORE=40, OVERLAP=0. Then C2 moved to (4,4) -> SCORE=40, OVERLAP=40.
- Early DONE after 25 points -> ERR=1, SCORE=0, SCORE_VALID=1 next cycle; with SCORER_CHECK_EN and EXP_SCORE=0 -> PASS=0.
- Gaps in PT_VALID (every other cycle low) still load exactly 40 points; RST asserted mid-EVAL -> all outputs 0 immediately, state LOAD; a rerun gives the correct score.
- SCORER_CHECK_EN: case 1 with EXP_SCORE=40 -> PASS=1; with EXP_SCORE=41 -> PASS=0.
